// File: rtl/led_ctrl_pkg.sv
// Shared types for the LED pattern controller: pattern modes, FSM states and
// the per-mode seed values loaded into q_led when a new configuration starts.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    JOHNSON = 2'd0,
    BINUP   = 2'd1,
    ROTATE  = 2'd2,
    HOLD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // HOLD has no seed: q_led keeps its value across a reload
  localparam int SEED_JOHNSON = 0;
  localparam int SEED_BINUP   = 0;
  localparam int SEED_ROTATE  = 1;

endpackage

// File: rtl/led_timebase.sv
// Free-running timebase with a speed-selected tick: tick fires when the low
// TB_WIDTH-speed_eff bits are all ones, giving a period of 2^(TB_WIDTH-speed_eff).
module led_timebase #(
  parameter int TB_WIDTH = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       run,
  input  logic [2:0] speed,
  output logic       tick
);

  logic [TB_WIDTH-1:0] cnt;
  logic [TB_WIDTH-1:0] mask;

  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (run)       cnt <= cnt + TB_WIDTH'(1);
  end

  // speed beyond TB_WIDTH-1 clamps to a single-bit decode (period 2)
  always_comb begin
    mask = {TB_WIDTH{1'b1}} >> speed;
    if (int'(speed) > TB_WIDTH - 1) mask = TB_WIDTH'(1);
  end

  assign tick = run && ((cnt & mask) == mask);

endmodule

// File: rtl/led_pattern_ctrl.sv
// Two-requester LED pattern controller: accepts a mode/speed configuration,
// reseeds in LOAD, then steps q_led on timebase ticks in RUN.
// Define LED_CTRL_RR_EN for round-robin arbitration; default is fixed priority.
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int TB_WIDTH = 23,
  parameter int LED_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [1:0]       req_mode0,
  input  logic [1:0]       req_mode1,
  input  logic [2:0]       req_speed0,
  input  logic [2:0]       req_speed1,
  output logic [1:0]       req_ready,
  output logic [LED_W-1:0] q_led,
  output logic [1:0]       mode,
  output logic             busy
);

  state_e     state, state_nxt;
  mode_e      mode_q;
  logic [2:0] speed_q;
  logic [1:0] grant;
  logic       accept, tick, can_accept;
  logic [LED_W-1:0] q_step, q_seed;

`ifdef LED_CTRL_RR_EN
  logic rr_ptr;

  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) grant = rr_ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (reset)       rr_ptr <= 1'b0;
    else if (accept) rr_ptr <= ~rr_ptr;
  end
`else
  assign grant = req_valid[0] ? 2'b01 : req_valid;
`endif

  assign can_accept = !reset && (state == IDLE || state == RUN);
  assign req_ready  = can_accept ? grant : 2'b00;
  assign accept     = |req_ready;
  assign busy       = (state == LOAD) && !reset;
  assign mode       = mode_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (accept) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    q_step = q_led;
    q_seed = q_led;
    case (mode_q)
      JOHNSON: begin
        q_step = {~q_led[0], q_led[LED_W-1:1]};
        q_seed = LED_W'(SEED_JOHNSON);
      end
      BINUP: begin
        q_step = q_led + LED_W'(1);
        q_seed = LED_W'(SEED_BINUP);
      end
      ROTATE: begin
        q_step = {q_led[0], q_led[LED_W-1:1]};
        q_seed = LED_W'(SEED_ROTATE);
      end
      default: ;
    endcase
  end

  // an accept in RUN wins over a coincident tick; the tick is simply lost
  always_ff @(posedge clk) begin
    if (reset) begin
      q_led   <= '0;
      mode_q  <= JOHNSON;
      speed_q <= '0;
    end else if (accept) begin
      mode_q  <= mode_e'(grant[1] ? req_mode1 : req_mode0);
      speed_q <= grant[1] ? req_speed1 : req_speed0;
    end else if (state == LOAD) begin
      q_led <= q_seed;
    end else if (tick) begin
      q_led <= q_step;
    end
  end

  led_timebase #(.TB_WIDTH(TB_WIDTH)) u_timebase (
    .clk   (clk),
    .reset (reset),
    .clear (state != RUN),
    .run   (state == RUN),
    .speed (speed_q),
    .tick  (tick)
  );

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl (TB_WIDTH=4, LED_W=8) against a
// cycle-level behavioural model plus directed constant checks.
module tb_led_pattern_ctrl;

  localparam int TBW = 4;
  localparam int LW  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_mode0, req_mode1;
  logic [2:0]    req_speed0, req_speed1;
  logic [1:0]    req_ready;
  logic [LW-1:0] q_led;
  logic [1:0]    mode;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_pattern_ctrl #(.TB_WIDTH(TBW), .LED_W(LW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_mode0  (req_mode0),
    .req_mode1  (req_mode1),
    .req_speed0 (req_speed0),
    .req_speed1 (req_speed1),
    .req_ready  (req_ready),
    .q_led      (q_led),
    .mode       (mode),
    .busy       (busy)
  );

  // model: phase 0=idle 1=load 2=run; m_run counts RUN cycles since LOAD
  int m_phase = 0, m_run = 0, m_mode = 0, m_speed = 0, m_q = 0;
  bit m_ptr = 1'b0;

  function automatic logic [1:0] m_grant(logic [1:0] v);
    if (v == 2'b11) begin
`ifdef LED_CTRL_RR_EN
      return m_ptr ? 2'b10 : 2'b01;
`else
      return 2'b01;
`endif
    end
    return v;
  endfunction

  function automatic logic [12:0] exp_vec();
    logic [1:0] r;
    r = (reset || m_phase == 1) ? 2'b00 : m_grant(req_valid);
    return {r, (m_phase == 1 && !reset), 2'(m_mode), 8'(m_q)};
  endfunction

  function automatic int next_q(int q, int md);
    case (md)
      0:       return (q >> 1) | (((q & 1) ^ 1) << 7);
      1:       return (q + 1) % 256;
      2:       return (q >> 1) | ((q & 1) << 7);
      default: return q;
    endcase
  endfunction

  task automatic apply(input logic r, input logic [1:0] v, input logic [1:0] m0,
                       input logic [1:0] m1, input logic [2:0] s0, input logic [2:0] s1);
    reset = r; req_valid = v; req_mode0 = m0; req_mode1 = m1;
    req_speed0 = s0; req_speed1 = s1;
    #2;
  endtask

  task automatic advance();
    logic [1:0] g;
    int se;
    g = (reset || m_phase == 1) ? 2'b00 : m_grant(req_valid);
    @(posedge clk);
    if (reset) begin
      m_phase = 0; m_run = 0; m_mode = 0; m_speed = 0; m_q = 0; m_ptr = 1'b0;
    end else if (g != 2'b00) begin
      m_mode  = g[1] ? int'(req_mode1)  : int'(req_mode0);
      m_speed = g[1] ? int'(req_speed1) : int'(req_speed0);
      m_phase = 1;
      m_ptr   = !m_ptr;
    end else if (m_phase == 1) begin
      m_phase = 2; m_run = 0;
      if (m_mode == 2)      m_q = 1;
      else if (m_mode != 3) m_q = 0;
    end else if (m_phase == 2) begin
      m_run++;
      se = (m_speed > TBW - 1) ? TBW - 1 : m_speed;
      if (m_run % (1 << (TBW - se)) == 0) m_q = next_q(m_q, m_mode);
    end
    #1;
  endtask

  task automatic test_reset();
    apply(1, 2'b11, 2'd1, 2'd2, 3'd3, 3'd3); advance();
    for (int i = 0; i < 2; i++) begin
      apply(1, 2'b11, 2'd1, 2'd2, 3'd3, 3'd3);
      checks++;
      if ({req_ready, busy, mode, q_led} !== exp_vec()) begin
        failures++;
        $display("FAIL reset_hold got=%h exp=%h", {req_ready, busy, mode, q_led}, exp_vec());
      end
      advance();
    end
    apply(0, 2'b00, 2'd0, 2'd0, 3'd0, 3'd0);
    checks++;
    if ({req_ready, busy, mode, q_led} !== 13'h0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", {req_ready, busy, mode, q_led}, 13'h0);
    end
    advance();
  endtask

  task automatic test_johnson();
    apply(0, 2'b01, 2'd0, 2'd0, 3'd0, 3'd0);
    checks++;
    if (req_ready !== 2'b01) begin
      failures++; $display("FAIL johnson_ready got=%b exp=01", req_ready);
    end
    advance();
    apply(0, 2'b00, 2'd0, 2'd0, 3'd0, 3'd0);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL johnson_busy got=%b exp=1", busy);
    end
    advance();
    for (int i = 1; i <= 256; i++) begin
      apply(0, 2'b00, 2'd0, 2'd0, 3'd0, 3'd0);
      checks++;
      if ({req_ready, busy, mode, q_led} !== exp_vec()) begin
        failures++;
        $display("FAIL johnson run=%0d got=%h exp=%h", i, {req_ready, busy, mode, q_led}, exp_vec());
      end
      if (i == 17 || i == 129 || i == 145) begin
        checks++;
        if (q_led !== ((i == 17) ? 8'h80 : (i == 129) ? 8'hFF : 8'h7F)) begin
          failures++; $display("FAIL johnson_seq run=%0d got=%h", i, q_led);
        end
      end
      advance();
    end
  endtask

  task automatic test_arb();
    logic [1:0] av [7];
    logic [1:0] er [7];
    av = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10};
`ifdef LED_CTRL_RR_EN
    er = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
`else
    er = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10};
`endif
    apply(1, 2'b00, 2'd0, 2'd0, 3'd0, 3'd0); advance();
    for (int i = 0; i < 7; i++) begin
      apply(0, av[i], 2'd1, 2'd2, 3'd3, 3'd1);
      checks++;
      if (req_ready !== er[i] || {req_ready, busy, mode, q_led} !== exp_vec()) begin
        failures++;
        $display("FAIL arb step=%0d ready=%b exp_ready=%b got=%h exp=%h", i, req_ready, er[i],
                 {req_ready, busy, mode, q_led}, exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_collision();
    apply(1, 2'b00, 2'd0, 2'd0, 3'd0, 3'd0); advance();
    apply(0, 2'b01, 2'd2, 2'd0, 3'd2, 3'd0); advance();
    apply(0, 2'b00, 2'd2, 2'd0, 3'd2, 3'd0); advance();
    for (int i = 1; i <= 4; i++) begin
      apply(0, (i == 4) ? 2'b01 : 2'b00, 2'd2, 2'd0, 3'd2, 3'd0);
      checks++;
      if ({req_ready, busy, mode, q_led} !== exp_vec() || q_led !== 8'h01) begin
        failures++;
        $display("FAIL collide_pre run=%0d got=%h exp=%h", i, {req_ready, busy, mode, q_led}, exp_vec());
      end
      advance();
    end
    apply(0, 2'b00, 2'd2, 2'd0, 3'd2, 3'd0); advance();
    for (int i = 1; i <= 5; i++) begin
      apply(0, 2'b00, 2'd2, 2'd0, 3'd2, 3'd0);
      checks++;
      if ({req_ready, busy, mode, q_led} !== exp_vec() || q_led !== ((i == 5) ? 8'h80 : 8'h01)) begin
        failures++;
        $display("FAIL collide_post run=%0d got=%h exp=%h", i, {req_ready, busy, mode, q_led}, exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_binup_hold();
    apply(1, 2'b00, 2'd0, 2'd0, 3'd0, 3'd0); advance();
    apply(0, 2'b01, 2'd1, 2'd0, 3'd3, 3'd0); advance();
    apply(0, 2'b00, 2'd1, 2'd0, 3'd3, 3'd0); advance();
    for (int i = 0; i <= 520; i++) begin
      apply(0, (i == 520) ? 2'b01 : 2'b00, (i == 520) ? 2'd3 : 2'd1, 2'd0, 3'd3, 3'd0);
      checks++;
      if ({req_ready, busy, mode, q_led} !== exp_vec()) begin
        failures++;
        $display("FAIL binup run=%0d got=%h exp=%h", i, {req_ready, busy, mode, q_led}, exp_vec());
      end
      if (i == 510 || i == 512 || i == 520) begin
        checks++;
        if (q_led !== ((i == 510) ? 8'hFF : (i == 512) ? 8'h00 : 8'h04)) begin
          failures++; $display("FAIL binup_wrap run=%0d got=%h", i, q_led);
        end
      end
      advance();
    end
    for (int i = 0; i < 21; i++) begin
      apply(0, 2'b00, 2'd3, 2'd0, 3'd3, 3'd0);
      checks++;
      if ({req_ready, busy, mode, q_led} !== exp_vec() || q_led !== 8'h04 || mode !== 2'd3) begin
        failures++;
        $display("FAIL hold cyc=%0d got=%h exp=%h", i, {req_ready, busy, mode, q_led}, exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_reset_in_load();
    apply(0, 2'b10, 2'd0, 2'd2, 3'd0, 3'd1); advance();
    apply(1, 2'b10, 2'd0, 2'd2, 3'd0, 3'd1);
    checks++;
    if (busy !== 1'b0 || req_ready !== 2'b00) begin
      failures++; $display("FAIL rst_load_outs busy=%b ready=%b exp=0/00", busy, req_ready);
    end
    advance();
    for (int i = 0; i < 6; i++) begin
      apply(0, 2'b00, 2'd0, 2'd2, 3'd0, 3'd1);
      checks++;
      if ({req_ready, busy, mode, q_led} !== 13'h0 || {req_ready, busy, mode, q_led} !== exp_vec()) begin
        failures++;
        $display("FAIL rst_load cyc=%0d got=%h exp=%h", i, {req_ready, busy, mode, q_led}, 13'h0);
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic       r;
    logic [1:0] v;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      apply(r, v, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      checks++;
      if ({req_ready, busy, mode, q_led} !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, {req_ready, busy, mode, q_led}, exp_vec());
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_johnson();
    test_arb();
    test_collision();
    test_binup_hold();
    test_reset_in_load();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 SHALL have parameter TB_WIDTH, default 23, giving the timebase counter width in bits; legal range is 4 to 32.
REQ-002 SHALL have parameter LED_W, default 8, giving the LED pattern width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 2 bits: per-requester configuration request.
REQ-006 SHALL have ports req_mode0 and req_mode1, input, 2 bits each: requested pattern mode.
REQ-007 SHALL have ports req_speed0 and req_speed1, input, 3 bits each: requested speed.
REQ-008 SHALL have port req_ready, output, 2 bits: per-requester accept; a transfer happens when valid and ready are both high in the same cycle.
REQ-009 SHALL have port q_led, output, LED_W bits: the current pattern.
REQ-010 SHALL have port mode, output, 2 bits: the active mode.
REQ-011 SHALL have port busy, output, 1 bit: high while the FSM is in LOAD.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD and RUN.
REQ-013 SHALL use these transitions: IDLE->LOAD on accept; LOAD->RUN unconditionally after 1 cycle; RUN->LOAD on accept.
REQ-014 SHALL drive req_ready combinationally; at most one bit is high, only in IDLE or RUN, and only toward a requester with valid high.
REQ-015 SHALL arbitrate between requesters per REQ-030/031 when both are valid in the same cycle.
REQ-016 SHALL register the granted mode and speed at the accept edge; the FSM is in LOAD in the following cycle.
REQ-017 SHALL, at the end of the LOAD cycle, clear the timebase and load q_led with the seed for the granted mode: mode 0 = 0; mode 1 = 0; mode 2 = 1 (bit 0 set); mode 3 = q_led unchanged.
REQ-018 SHALL assert tick in RUN when timebase bits [TB_WIDTH-1-speed_eff:0] are all ones; speed_eff = min(speed, TB_WIDTH-1); tick period is 2^(TB_WIDTH-speed_eff) cycles.
REQ-019 SHALL free-run the timebase in RUN and wrap it to 0 after all-ones.
REQ-020 SHALL hold the timebase at 0 in IDLE.
REQ-021 SHALL step q_led on each tick according to mode: 0 = Johnson, next = {~q[0], q[LED_W-1:1]}; 1 = binary up-count, wrapping from all-ones to 0; 2 = rotate right, next = {q[0], q[LED_W-1:1]}; 3 = hold.
REQ-022 SHALL give an accept priority over a tick in the same RUN cycle; the tick is dropped and q_led does not step.
REQ-023 SHALL deassert both req_ready bits during LOAD; a request held valid waits and is not lost.
REQ-024 SHALL make the first step after LOAD occur at the end of RUN cycle 2^(TB_WIDTH-speed_eff), counting the first RUN cycle as 1.

Reset
REQ-025 SHALL, while reset is high at a clock edge, set state to IDLE, the timebase to 0, q_led to 0, mode to 0, speed to 0 and the round-robin pointer to requester 0.
REQ-026 SHALL hold req_ready at 0 and busy at 0 during any cycle in which reset is high.
REQ-027 SHALL abort a LOAD in progress when reset is applied, without applying the configuration.
REQ-028 SHALL not accept a request in a cycle in which reset is high.

Configuration
REQ-029 SHALL provide macro LED_CTRL_RR_EN to select the arbitration scheme.
REQ-030 SHALL, with LED_CTRL_RR_EN defined, use round-robin: the pointer names the preferred requester and toggles to the other requester after each grant.
REQ-031 SHALL, without LED_CTRL_RR_EN, use fixed priority with requester 0 always winning, and include no pointer register.

Structure
REQ-032 SHALL define package led_ctrl_pkg containing the mode enum (JOHNSON, BINUP, ROTATE, HOLD), the state enum (IDLE, LOAD, RUN) and the per-mode seed constants.
REQ-033 SHALL place the timebase counter and the speed-select tick decode in sub-module led_timebase, with inputs clk, reset, clear, run and speed and output tick.

Verification (TB_WIDTH=4, LED_W=8)
REQ-034 SHALL cover: reset, then req0 with mode 0 and speed 0 -> ready0 high in 1 cycle, busy for 1 cycle, q_led steps every 16 cycles through 00, 80, C0, E0 ... FF, 7F ... 00.
REQ-035 SHALL cover: req0 and req1 both valid in IDLE, with RR enabled -> req0 granted; req1 granted at the next accept; a second simultaneous request is granted to req0.
REQ-036 SHALL cover: the same as REQ-035 without LED_CTRL_RR_EN -> req0 wins every simultaneous request, and req1 is granted only when req0 is idle.
REQ-037 SHALL cover: mode 2, speed 2, an accept landing on the tick cycle -> tick dropped, q_led reseeded to 01, next step 4 cycles after LOAD.
REQ-038 SHALL cover: mode 1, speed 3 (period 2), run 512 cycles -> q_led wraps FF->00; then a mode 3 request freezes q_led at its current value.
REQ-039 SHALL cover: reset asserted during LOAD -> next cycle is IDLE, q_led=00, mode=0, and the pending configuration is not applied.
